// File: rtl/subtractors_pipe.sv
// Multi-lane modular subtractor: C_i = (A_i - B_i) mod q.
// Two-stage valid/ready pipeline (difference, then +q correction on borrow).
module subtractors_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned N_SUBS = 51
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_SUBS*WIDTH-1:0]   in_first_points,
  input  logic [N_SUBS*WIDTH-1:0]   in_second_points,
  input  logic [WIDTH-1:0]          modulus,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_SUBS*WIDTH-1:0]   out_sub_result
);

  localparam int unsigned DW = WIDTH + 1;

  logic [N_SUBS-1:0][DW-1:0] s1_diff_q, s1_diff_d;
  logic [WIDTH-1:0]          s1_mod_q, s1_mod_d;
  logic                      s1_valid_q, s1_valid_d;
  logic [N_SUBS*WIDTH-1:0]   s2_res_q, s2_res_d;
  logic                      s2_valid_q, s2_valid_d;

  logic s2_load_c;
  logic s1_load_c;
  logic accept_c;

  // Handshake: S2 advances when empty or drained; S1 when empty or advancing.
  always_comb begin
    s2_load_c = !s2_valid_q || out_ready;
    s1_load_c = !s1_valid_q || s2_load_c;
    accept_c  = in_valid && s1_load_c;
  end

  assign in_ready       = s1_load_c;
  assign out_valid      = s2_valid_q;
  assign out_sub_result = s2_res_q;

  // Stage 1: raw (WIDTH+1)-bit difference; the top bit is the borrow.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_diff_d  = s1_diff_q;
    s1_mod_d   = s1_mod_q;
    if (s1_load_c) begin
      s1_valid_d = accept_c;
    end
    if (accept_c) begin
      s1_mod_d = modulus;
      for (int unsigned i = 0; i < N_SUBS; i++) begin
        s1_diff_d[i] = {1'b0, in_first_points[i*WIDTH +: WIDTH]}
                     - {1'b0, in_second_points[i*WIDTH +: WIDTH]};
      end
    end
  end

  // Stage 2: add q back wherever the subtraction borrowed.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_res_d   = s2_res_q;
    if (s2_load_c) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        for (int unsigned i = 0; i < N_SUBS; i++) begin
          s2_res_d[i*WIDTH +: WIDTH] = s1_diff_q[i][WIDTH]
                                     ? s1_diff_q[i][WIDTH-1:0] + s1_mod_q
                                     : s1_diff_q[i][WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_diff_q  <= '0;
      s1_mod_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_diff_q  <= s1_diff_d;
      s1_mod_q   <= s1_mod_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
    end
  end

endmodule

// File: tb/tb_subtractors_pipe.sv
// Scoreboard bench for subtractors_pipe: driver pushes expected results,
// a negedge monitor pops and compares on every output transfer.
module tb_subtractors_pipe;

  localparam int unsigned W  = 32;
  localparam int unsigned N  = 4;
  localparam int unsigned BW = N * W;

  typedef logic [BW-1:0] vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  vec_t          in_first_points;
  vec_t          in_second_points;
  logic [W-1:0]  modulus;
  logic          out_valid;
  logic          out_ready;
  vec_t          out_sub_result;

  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;
  int   cyc      = 0;

  subtractors_pipe #(.WIDTH(W), .N_SUBS(N)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_first_points  (in_first_points),
    .in_second_points (in_second_points),
    .modulus          (modulus),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_sub_result   (out_sub_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input vec_t act, input vec_t req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic vec_t rep(input logic [W-1:0] x);
    return {N{x}};
  endfunction

  function automatic vec_t model(input vec_t a, input vec_t b, input logic [W-1:0] q);
    vec_t r;
    logic [W-1:0] la, lb;
    r = '0;
    for (int i = 0; i < N; i++) begin
      la = a[i*W +: W];
      lb = b[i*W +: W];
      r[i*W +: W] = (la >= lb) ? la - lb : la - lb + q;
    end
    return r;
  endfunction

  // Monitor: every output transfer must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got %h required none", out_sub_result);
      end else begin
        chk("output", out_sub_result, exp_q.pop_front());
      end
      n_out++;
    end
  end

  task automatic send(input vec_t a, input vec_t b, input logic [W-1:0] q, input vec_t e);
    int waited = 0;
    in_first_points  = a;
    in_second_points = b;
    modulus          = q;
    in_valid         = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 required 1");
    end else begin
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t a, b, hold;
    logic [W-1:0] q;
    int start, n0, acc, waited;
    bit have;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_first_points = '0; in_second_points = '0; modulus = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", BW'(out_valid), BW'(0));
    chk("rst_in_ready", BW'(in_ready), BW'(1));
    chk("rst_result", out_sub_result, '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Mixed lanes with q=17; also checks the two-cycle latency.
    a = {32'd0, 32'd0, 32'd3, 32'd5};
    b = {32'd16, 32'd0, 32'd5, 32'd3};
    send(a, b, 32'd17, {32'd1, 32'd0, 32'd15, 32'd2});
    @(negedge clk);
    chk("latency_c1", BW'(out_valid), BW'(0));
    @(negedge clk);
    chk("latency_c2", BW'(out_valid), BW'(1));
    drain();

    // Near-full-range modulus.
    send(rep(32'd0), rep(32'hFFFF_FFFA), 32'hFFFF_FFFB, rep(32'd1));
    send(rep(32'hFFFF_FFFA), rep(32'd0), 32'hFFFF_FFFB, rep(32'hFFFF_FFFA));
    // q changes between consecutive transactions.
    send(rep(32'd3), rep(32'd5), 32'd17, rep(32'd15));
    send(rep(32'd3), rep(32'd5), 32'd97, rep(32'd95));
    drain();

    // Back-to-back random stream at full throughput.
    start = cyc;
    n0 = n_out;
    for (int t = 0; t < 100; t++) begin
      for (int i = 0; i < N; i++) begin
        a[i*W +: W] = $urandom;
        b[i*W +: W] = $urandom;
      end
      q = $urandom;
      send(a, b, q, model(a, b, q));
    end
    drain();
    chk("rand_count", BW'(n_out - n0), BW'(100));
    chk("rand_throughput", BW'(cyc - start <= 104), BW'(1));

    // Backpressure: only two transactions fit, output held stable.
    out_ready = 1'b0;
    fork
      begin
        send(rep(32'd1), rep(32'd0), 32'd17, rep(32'd1));
        send(rep(32'd2), rep(32'd0), 32'd17, rep(32'd2));
        send(rep(32'd3), rep(32'd0), 32'd17, rep(32'd3));
      end
    join_none
    acc = 0; have = 1'b0; hold = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      if (out_valid) begin
        if (!have) begin
          hold = out_sub_result;
          have = 1'b1;
        end else begin
          chk("hold_stable", out_sub_result, hold);
        end
      end
    end
    chk("bp_accepted", BW'(acc), BW'(2));
    chk("bp_in_ready", BW'(in_ready), BW'(0));
    chk("bp_out_valid", BW'(out_valid), BW'(1));
    chk("bp_head", out_sub_result, rep(32'd1));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait fork;
    drain();

    // Reset with both stages full discards everything in flight.
    out_ready = 1'b0;
    fork
      begin
        send(rep(32'd4), rep(32'd0), 32'd17, rep(32'd4));
        send(rep(32'd5), rep(32'd0), 32'd17, rep(32'd5));
      end
    join_none
    waited = 0;
    @(negedge clk);
    while (in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("full_in_ready", BW'(in_ready), BW'(0));
    wait fork;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", BW'(out_valid), BW'(0));
    chk("rst_async_ready", BW'(in_ready), BW'(1));
    chk("rst_async_result", out_sub_result, '0);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n0 = n_out;
    send(rep(32'd9), rep(32'd2), 32'd17, rep(32'd7));
    drain();
    repeat (3) @(negedge clk);
    chk("post_reset_count", BW'(n_out - n0), BW'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
